// File: rtl/jk_shift_reg.sv
// Universal shift register built from JK storage cells.
// Includes a burst serializer that shifts all bits out LSB-first on start.
module jk_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dsel;
    logic [WIDTH-1:0] j, k;
    logic             en;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        en      = 1'b0;
        dsel    = q_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BURST;
                    cnt_d   = '0;
                end else begin
                    unique case (mode)
                        2'b00: en = 1'b0;
                        2'b01: begin
                            en   = 1'b1;
                            dsel = {ser_in_r, q_q[WIDTH-1:1]};
                        end
                        2'b10: begin
                            en   = 1'b1;
                            dsel = {q_q[WIDTH-2:0], ser_in_l};
                        end
                        2'b11: begin
                            en   = 1'b1;
                            dsel = par_in;
                        end
                    endcase
                end
            end
            BURST: begin
                en    = 1'b1;
                dsel  = {ser_in_r, q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // j=d, k=~d when enabled; j=k=0 holds, so toggle never occurs
    assign j   = {WIDTH{en}} & dsel;
    assign k   = {WIDTH{en}} & ~dsel;
    assign q_d = (j & ~q_q) | (~k & q_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q       = q_q;
    assign nq      = ~q_q;
    assign ser_out = q_q[0];
    assign busy    = (state_q == BURST);
    assign done    = done_q;

endmodule

// File: tb/tb_jk_shift_reg.sv
// Testbench for jk_shift_reg: scoreboard of expected q/busy/done per edge.
// Burst serial bits are queued at start and popped before each burst edge.
module tb_jk_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic         ser_in_r, ser_in_l, start;
    logic [W-1:0] par_in, q, nq;
    logic         ser_out, busy, done;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t   sb[$];
    logic   serq[$];
    exp_t   e;
    logic   sbit;
    logic [W-1:0] m;
    int     checks = 0;
    int     errors = 0;

    jk_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
        .par_in(par_in), .start(start),
        .q(q), .nq(nq), .ser_out(ser_out),
        .busy(busy), .done(done)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 2'b00; start = 1'b0;
        ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = '0;
        #3;
        checks++;
        if ({q, nq, busy, done} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: q=%h nq=%h busy=%b done=%b expected 00 ff 0 0",
                     q, nq, busy, done);
        end
        clk_en = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_load_hold();
        mode = 2'b11; par_in = 8'hA5;
        sb.push_back('{8'hA5, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL load_hold[%0d]: q=%h nq=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         i, q, nq, busy, done, e.q, e.busy, e.done);
            end
            mode = 2'b00; par_in = 8'h3C;
            sb.push_back('{8'hA5, 1'b0, 1'b0});
        end
        sb.delete();
    endtask

    task automatic test_shift();
        mode = 2'b11; par_in = 8'h81;
        sb.push_back('{8'h81, 1'b0, 1'b0});
        sb.push_back('{8'hC0, 1'b0, 1'b0});
        sb.push_back('{8'h80, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL shift[%0d]: q=%h nq=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         i, q, nq, busy, done, e.q, e.busy, e.done);
            end
            if (i == 0) begin
                mode = 2'b01; ser_in_r = 1'b1; ser_in_l = 1'b1;
            end else begin
                mode = 2'b10; ser_in_l = 1'b0; ser_in_r = 1'b1;
            end
        end
    endtask

    task automatic test_burst();
        mode = 2'b11; par_in = 8'h96; start = 1'b0;
        tick();
        mode = 2'b00; start = 1'b1; ser_in_r = 1'b0;
        m = 8'h96;
        sb.push_back('{m, 1'b1, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL burst_start: q=%h busy=%b done=%b expected q=%h busy=1 done=0",
                     q, busy, done, e.q);
        end
        start = 1'b0;
        for (int i = 0; i < W; i++) serq.push_back(m[i]);
        for (int i = 0; i < W; i++) begin
            sbit = serq.pop_front();
            checks++;
            if (ser_out !== sbit || busy !== 1'b1) begin
                errors++;
                $display("FAIL burst_ser[%0d]: ser_out=%b busy=%b expected ser_out=%b busy=1",
                         i, ser_out, busy, sbit);
            end
            m = {1'b0, m[W-1:1]};
            sb.push_back('{m, (i < W - 1), (i == W - 1)});
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL burst[%0d]: q=%h nq=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         i, q, nq, busy, done, e.q, e.busy, e.done);
            end
        end
        sb.push_back('{8'h00, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL burst_done_pulse: q=%h busy=%b done=%b expected q=00 busy=0 done=0",
                     q, busy, done);
        end
    endtask

    task automatic test_priority();
        mode = 2'b11; par_in = 8'h3C;
        tick();
        m = 8'h3C;
        mode = 2'b11; par_in = 8'hFF; start = 1'b1;
        sb.push_back('{m, 1'b1, 1'b0});
        for (int i = 0; i <= W; i++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL priority[%0d]: q=%h nq=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         i, q, nq, busy, done, e.q, e.busy, e.done);
            end
            if (i < W) begin
                mode     = 2'($urandom_range(3));
                par_in   = 8'($urandom);
                ser_in_l = 1'($urandom);
                ser_in_r = 1'($urandom);
                start    = 1'($urandom);
                m = {ser_in_r, m[W-1:1]};
                sb.push_back('{m, (i < W - 1), (i == W - 1)});
            end
        end
        start = 1'b0; mode = 2'b00;
        sb.push_back('{m, 1'b0, 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL priority_end: q=%h busy=%b done=%b expected q=%h busy=0 done=0",
                     q, busy, done, e.q);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'b11; par_in = 8'h5A; start = 1'b0;
        tick();
        m = 8'h5A;
        mode = 2'b00; start = 1'b1; ser_in_r = 1'b0;
        for (int b = 0; b < 2; b++) begin
            sb.push_back('{m, 1'b1, 1'b0});
            for (int i = 0; i < W; i++) begin
                m = {ser_in_r, m[W-1:1]};
                sb.push_back('{m, (i < W - 1), (i == W - 1)});
            end
            ser_in_r = 1'b1;
        end
        sb.push_back('{m, 1'b0, 1'b0});
        ser_in_r = 1'b0;
        for (int i = 0; i < 2 * (W + 1) + 1; i++) begin
            if (i == 2 * (W + 1)) start = 1'b0;
            if (i == W + 1) ser_in_r = 1'b1;
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: q=%h nq=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         i, q, nq, busy, done, e.q, e.busy, e.done);
            end
        end
        start = 1'b0; ser_in_r = 1'b0;
    endtask

    task automatic test_abort();
        mode = 2'b11; par_in = 8'h96;
        tick();
        mode = 2'b00; start = 1'b1; ser_in_r = 1'b1;
        tick();
        start = 1'b0;
        m = 8'h96;
        for (int i = 0; i < 3; i++) begin
            m = {1'b1, m[W-1:1]};
            sb.push_back('{m, 1'b1, 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL abort_pre[%0d]: q=%h busy=%b done=%b expected q=%h busy=1 done=0",
                         i, q, busy, done, e.q);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({q, nq, busy, done} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_async: q=%h nq=%h busy=%b done=%b expected 00 ff 0 0",
                     q, nq, busy, done);
        end
        tick();
        rst = 1'b1;
        m = 8'h00;
        sb.push_back('{m, 1'b0, 1'b0});
        sb.push_back('{m, 1'b0, 1'b0});
        sb.push_back('{m, 1'b1, 1'b0});
        for (int i = 0; i < W; i++) begin
            m = {1'b1, m[W-1:1]};
            sb.push_back('{m, (i < W - 1), (i == W - 1)});
        end
        sb.push_back('{m, 1'b0, 1'b0});
        for (int i = 0; i < W + 4; i++) begin
            start = (i == 2);
            tick();
            e = sb.pop_front();
            checks++;
            if ({q, nq, busy, done} !== {e.q, ~e.q, e.busy, e.done}) begin
                errors++;
                $display("FAIL abort_post[%0d]: q=%h nq=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         i, q, nq, busy, done, e.q, e.busy, e.done);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shift();
        test_burst();
        test_priority();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
